lx_mem_arbiter: RTL and testbench

- Shares the single lower-level memory port between the instruction-cache miss path and the data-cache miss/writeback path.
- Accepts one outstanding transaction at a time, arbitrates round-robin and forwards the block response to the owning requester.
- Provides a response watchdog so a lost memory response cannot deadlock the fetch stage.
- Sits between the icache/dcache lower-level request ports and the external memory interface.

---
 rtl/lx_mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_lx_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lx_mem_arbiter.sv
// lx_mem_arbiter: shares the single lower-level memory port between the
// icache miss path and the dcache miss/writeback path. One transaction is
// outstanding at a time, with round-robin grant, zero-latency response
// forwarding to the owner and a response watchdog on the wait phase.
// rst_ni is a synchronous, active-high reset.

module lx_mem_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BLK_SIZE = 128,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // icache lower-level port
  input  logic                i_req_valid_i,
  input  logic [XLEN-1:0]     i_req_addr_i,
  input  logic                i_req_uncached_i,
  output logic                i_req_ready_o,
  output logic                i_res_valid_o,
  output logic [BLK_SIZE-1:0] i_res_data_o,
  output logic                i_res_err_o,
  // dcache lower-level port
  input  logic                d_req_valid_i,
  input  logic [XLEN-1:0]     d_req_addr_i,
  input  logic                d_req_rw_i,
  input  logic [BLK_SIZE-1:0] d_req_wdata_i,
  input  logic                d_req_uncached_i,
  output logic                d_req_ready_o,
  output logic                d_res_valid_o,
  output logic [BLK_SIZE-1:0] d_res_data_o,
  output logic                d_res_err_o,
  // external memory port
  output logic                mem_req_valid_o,
  output logic [XLEN-1:0]     mem_req_addr_o,
  output logic                mem_req_rw_o,
  output logic [BLK_SIZE-1:0] mem_req_wdata_o,
  output logic                mem_req_uncached_o,
  input  logic                mem_req_ready_i,
  input  logic                mem_res_valid_i,
  input  logic [BLK_SIZE-1:0] mem_res_data_i,
  // sticky error flag
  output logic                err_o
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  localparam logic OwnI = 1'b0;
  localparam logic OwnD = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [BLK_SIZE-1:0]   wdata_q, wdata_d;
  logic                  unc_q, unc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  grant_i, grant_d;
  logic                  res_fire, res_err;
  logic                  res_valid;
  logic                  active;

  // Outputs are suppressed while reset is held so nothing leaks mid-reset.
  assign active = ~rst_ni;

  // Round-robin pick: a lone requester always wins; on conflict the one that
  // was not granted last time wins.
  always_comb begin
    grant_i = i_req_valid_i & (~d_req_valid_i | (last_grant_q == OwnD));
    grant_d = d_req_valid_i & (~i_req_valid_i | (last_grant_q == OwnI));
  end

  // Next-state logic: transaction sequencing, field capture and watchdog.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    unc_d        = unc_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    res_fire     = 1'b0;
    res_err      = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_i) begin
          owner_d      = OwnI;
          last_grant_d = OwnI;
          addr_d       = i_req_addr_i;
          rw_d         = 1'b0;
          wdata_d      = '0;
          unc_d        = i_req_uncached_i;
          state_d      = StIssue;
        end else if (grant_d) begin
          owner_d      = OwnD;
          last_grant_d = OwnD;
          addr_d       = d_req_addr_i;
          rw_d         = d_req_rw_i;
          wdata_d      = d_req_wdata_i;
          unc_d        = d_req_uncached_i;
          state_d      = StIssue;
        end
        // Nothing is outstanding, so any response here is unsolicited.
        if (mem_res_valid_i) begin
          err_d = 1'b1;
        end
      end

      StIssue: begin
        if (mem_res_valid_i) begin
          err_d = 1'b1;
        end
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end

      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // A real response beats a coincident timeout.
        if (mem_res_valid_i) begin
          res_fire = 1'b1;
          state_d  = StIdle;
        end else if (cnt_q == CntMax) begin
          res_fire = 1'b1;
          res_err  = 1'b1;
          err_d    = 1'b1;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and captured-request registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_q      <= StIdle;
      owner_q      <= OwnI;
      last_grant_q <= OwnI;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      wdata_q      <= '0;
      unc_q        <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      wdata_q      <= wdata_d;
      unc_q        <= unc_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  // Request-side handshakes and memory request fields.
  always_comb begin
    i_req_ready_o      = active & (state_q == StIdle) & grant_i;
    d_req_ready_o      = active & (state_q == StIdle) & grant_d;
    mem_req_valid_o    = active & (state_q == StIssue);
    mem_req_addr_o     = addr_q;
    mem_req_rw_o       = rw_q;
    mem_req_wdata_o    = wdata_q;
    mem_req_uncached_o = unc_q;
    err_o              = err_q;
  end

  // Response steering: only the owner sees a pulse; data is zero when idle
  // and on a timeout error.
  always_comb begin
    res_valid     = active & res_fire;
    i_res_valid_o = res_valid & (owner_q == OwnI);
    d_res_valid_o = res_valid & (owner_q == OwnD);
    i_res_err_o   = i_res_valid_o & res_err;
    d_res_err_o   = d_res_valid_o & res_err;
    i_res_data_o  = (i_res_valid_o & ~res_err) ? mem_res_data_i : '0;
    d_res_data_o  = (d_res_valid_o & ~res_err) ? mem_res_data_i : '0;
  end

endmodule

// File: tb/tb_lx_mem_arbiter.sv
// Bench for lx_mem_arbiter: table of single transactions plus hand-written
// sequences for arbitration, stalls, timeout, unsolicited responses and
// reset mid-transaction. Responses are checked against a scoreboard queue.

module tb_lx_mem_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BLK  = 128;
  localparam int unsigned TO   = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            i_req_valid_i, i_req_uncached_i, i_req_ready_o;
  logic [XLEN-1:0] i_req_addr_i;
  logic            i_res_valid_o, i_res_err_o;
  logic [BLK-1:0]  i_res_data_o;
  logic            d_req_valid_i, d_req_rw_i, d_req_uncached_i, d_req_ready_o;
  logic [XLEN-1:0] d_req_addr_i;
  logic [BLK-1:0]  d_req_wdata_i;
  logic            d_res_valid_o, d_res_err_o;
  logic [BLK-1:0]  d_res_data_o;
  logic            mem_req_valid_o, mem_req_rw_o, mem_req_uncached_o;
  logic [XLEN-1:0] mem_req_addr_o;
  logic [BLK-1:0]  mem_req_wdata_o;
  logic            mem_req_ready_i, mem_res_valid_i;
  logic [BLK-1:0]  mem_res_data_i;
  logic            err_o;

  lx_mem_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_req_valid_i(i_req_valid_i), .i_req_addr_i(i_req_addr_i),
    .i_req_uncached_i(i_req_uncached_i), .i_req_ready_o(i_req_ready_o),
    .i_res_valid_o(i_res_valid_o), .i_res_data_o(i_res_data_o), .i_res_err_o(i_res_err_o),
    .d_req_valid_i(d_req_valid_i), .d_req_addr_i(d_req_addr_i), .d_req_rw_i(d_req_rw_i),
    .d_req_wdata_i(d_req_wdata_i), .d_req_uncached_i(d_req_uncached_i),
    .d_req_ready_o(d_req_ready_o), .d_res_valid_o(d_res_valid_o),
    .d_res_data_o(d_res_data_o), .d_res_err_o(d_res_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_rw_o(mem_req_rw_o), .mem_req_wdata_o(mem_req_wdata_o),
    .mem_req_uncached_o(mem_req_uncached_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_res_valid_i(mem_res_valid_i), .mem_res_data_i(mem_res_data_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic           owner;
    logic [BLK-1:0] data;
    logic           err;
  } res_t;

  typedef struct {
    logic           iv;
    logic [31:0]    ia;
    logic           iu;
    logic           dv;
    logic [31:0]    da;
    logic           drw;
    logic [BLK-1:0] dwd;
    logic           du;
    logic [BLK-1:0] mdata;
    int             hold;
    logic           eo;
    logic [31:0]    ea;
    logic           erw;
    logic [BLK-1:0] ewd;
    logic           eu;
  } vec_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (i_res_valid_o === 1'b1 || d_res_valid_o === 1'b1) begin
        n_cmp++;
        if (i_res_valid_o && d_res_valid_o) begin
          n_bad++;
          $display("FAIL res_both: got i=1 d=1 expected one owner");
        end else if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL res_unexpected: got i=%0b d=%0b expected none",
                   i_res_valid_o, d_res_valid_o);
        end else begin
          res_t e;
          logic [BLK-1:0] ad;
          logic ae;
          e  = exp_q.pop_front();
          ad = d_res_valid_o ? d_res_data_o : i_res_data_o;
          ae = d_res_valid_o ? d_res_err_o : i_res_err_o;
          if (d_res_valid_o !== e.owner || ad !== e.data || ae !== e.err) begin
            n_bad++;
            $display("FAIL res: got owner=%0b data=%h err=%0b expected owner=%0b data=%h err=%0b",
                     d_res_valid_o, ad, ae, e.owner, e.data, e.err);
          end
        end
      end
      if (i_res_valid_o !== 1'b1) chk("i_res_data_idle", i_res_data_o, '0);
      if (d_res_valid_o !== 1'b1) chk("d_res_data_idle", d_res_data_o, '0);
      chk("ready_both", i_req_ready_o & d_req_ready_o, 0);
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1; i_req_valid_i = 1'b1; d_req_valid_i = 1'b1;
    mem_req_ready_i = 1'b0; mem_res_valid_i = 1'b0; mem_res_data_i = '0;
    repeat (2) begin
      @(negedge clk_i);
      chk("rst_i_ready", i_req_ready_o, 0);
      chk("rst_d_ready", d_req_ready_o, 0);
      chk("rst_mem_valid", mem_req_valid_o, 0);
      chk("rst_i_res", i_res_valid_o, 0);
      chk("rst_d_res", d_res_valid_o, 0);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b0; i_req_valid_i = 1'b0; d_req_valid_i = 1'b0;
    mon_en = 1'b1;
    @(negedge clk_i);
    chk("rst_err", err_o, 0);
    chk("rst_mem_valid_after", mem_req_valid_o, 0);
    @(posedge clk_i); #1;
  endtask

  // Caller drives request valids at posedge+1 of an IDLE cycle; this runs the
  // accept, issue (stalled for hold cycles) and response phases.
  task automatic do_txn(input logic owner, input logic [31:0] addr, input logic rw,
                        input logic [BLK-1:0] wdata, input logic unc,
                        input logic [BLK-1:0] data, input int hold, input bit drop);
    @(negedge clk_i);
    chk("i_ready", i_req_ready_o, owner == 1'b0);
    chk("d_ready", d_req_ready_o, owner == 1'b1);
    @(posedge clk_i); #1;
    if (drop) begin
      if (owner) d_req_valid_i = 1'b0;
      else       i_req_valid_i = 1'b0;
    end
    for (int h = 0; h <= hold; h++) begin
      mem_req_ready_i = (h == hold);
      @(negedge clk_i);
      chk("mem_valid", mem_req_valid_o, 1);
      chk("mem_addr", mem_req_addr_o, addr);
      chk("mem_rw", mem_req_rw_o, rw);
      chk("mem_wdata", mem_req_wdata_o, wdata);
      chk("mem_unc", mem_req_uncached_o, unc);
      chk("issue_ready", i_req_ready_o | d_req_ready_o, 0);
      @(posedge clk_i); #1;
    end
    mem_req_ready_i = 1'b0;
    mem_res_valid_i = 1'b1;
    mem_res_data_i  = data;
    exp_q.push_back('{owner: owner, data: data, err: 1'b0});
    @(negedge clk_i);
    chk("wait_mem_valid", mem_req_valid_o, 0);
    @(posedge clk_i); #1;
    mem_res_valid_i = 1'b0;
    mem_res_data_i  = '0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [BLK-1:0] a5, pat1, ones, pat5;
    a5   = {16{8'hA5}};
    pat1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    ones = '1;
    pat5 = {16{8'h5A}};
    // {iv, ia, iu, dv, da, drw, dwd, du, mdata, hold, eo, ea, erw, ewd, eu}
    vecs[0] = '{1, 32'h4000_0000, 0, 0, 0, 0, 0, 0, a5, 0,
                0, 32'h4000_0000, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 1, 32'h8000_0010, 1, 128'h1234, 0, 128'h0, 5,
                1, 32'h8000_0010, 1, 128'h1234, 0};
    vecs[2] = '{1, 32'h100, 1, 1, 32'h200, 1, 128'hDEAD_BEEF, 0, pat1, 1,
                0, 32'h100, 0, 0, 1};
    vecs[3] = '{0, 0, 0, 1, 32'h200, 1, 128'hDEAD_BEEF, 0, 128'h0, 0,
                1, 32'h200, 1, 128'hDEAD_BEEF, 0};
    vecs[4] = '{1, 32'h300, 0, 1, 32'h400, 0, 0, 1, ones, 2,
                0, 32'h300, 0, 0, 0};
    vecs[5] = '{0, 0, 0, 1, 32'h400, 0, 0, 1, pat5, 0,
                1, 32'h400, 0, 0, 1};

    rst_ni = 1'b1;
    i_req_valid_i = 0; i_req_addr_i = 0; i_req_uncached_i = 0;
    d_req_valid_i = 0; d_req_addr_i = 0; d_req_rw_i = 0; d_req_wdata_i = 0;
    d_req_uncached_i = 0;
    mem_req_ready_i = 0; mem_res_valid_i = 0; mem_res_data_i = 0;

    do_reset();
    chk("rst_addr", mem_req_addr_o, 0);
    chk("rst_wdata", mem_req_wdata_o, 0);

    // Table of transactions; losers stay pending into the next row.
    for (int v = 0; v < 6; v++) begin
      i_req_valid_i = vecs[v].iv; i_req_addr_i = vecs[v].ia; i_req_uncached_i = vecs[v].iu;
      d_req_valid_i = vecs[v].dv; d_req_addr_i = vecs[v].da; d_req_rw_i = vecs[v].drw;
      d_req_wdata_i = vecs[v].dwd; d_req_uncached_i = vecs[v].du;
      do_txn(vecs[v].eo, vecs[v].ea, vecs[v].erw, vecs[v].ewd, vecs[v].eu,
             vecs[v].mdata, vecs[v].hold, 1'b1);
    end
    i_req_valid_i = 0; d_req_valid_i = 0;
    chk("err_clean", err_o, 0);

    // Watchdog: no response; error pulse on the 16th WAIT cycle.
    i_req_valid_i = 1; i_req_addr_i = 32'h500; i_req_uncached_i = 0;
    @(negedge clk_i);
    chk("to_i_ready", i_req_ready_o, 1);
    @(posedge clk_i); #1;
    i_req_valid_i = 0; mem_req_ready_i = 1;
    @(negedge clk_i);
    chk("to_mem_valid", mem_req_valid_o, 1);
    @(posedge clk_i); #1;
    mem_req_ready_i = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) exp_q.push_back('{owner: 1'b0, data: '0, err: 1'b1});
      @(negedge clk_i);
      if (k < 16) chk("to_early", i_res_valid_o, 0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("to_err_sticky", err_o, 1);
    @(posedge clk_i); #1;
    d_req_valid_i = 1; d_req_addr_i = 32'h600; d_req_rw_i = 0; d_req_wdata_i = 0;
    d_req_uncached_i = 0;
    do_txn(1'b1, 32'h600, 1'b0, '0, 1'b0, pat1, 0, 1'b1);
    @(negedge clk_i);
    chk("to_err_still", err_o, 1);
    @(posedge clk_i); #1;

    // Unsolicited response in IDLE.
    do_reset();
    mem_res_valid_i = 1; mem_res_data_i = 128'h77;
    @(negedge clk_i);
    chk("unsol_i_res", i_res_valid_o, 0);
    chk("unsol_d_res", d_res_valid_o, 0);
    @(posedge clk_i); #1;
    mem_res_valid_i = 0; mem_res_data_i = 0;
    @(negedge clk_i);
    chk("unsol_err", err_o, 1);
    @(posedge clk_i); #1;

    // Reset while waiting, then a late response.
    do_reset();
    d_req_valid_i = 1; d_req_addr_i = 32'h700; d_req_rw_i = 0;
    @(negedge clk_i);
    chk("rw_d_ready", d_req_ready_o, 1);
    @(posedge clk_i); #1;
    d_req_valid_i = 0; mem_req_ready_i = 1;
    @(posedge clk_i); #1;
    mem_req_ready_i = 0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rw_rst_d_res", d_res_valid_o, 0);
    chk("rw_rst_mem_valid", mem_req_valid_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rw_err_clear", err_o, 0);
    chk("rw_idle_mem_valid", mem_req_valid_o, 0);
    @(posedge clk_i); #1;
    mem_res_valid_i = 1; mem_res_data_i = 128'h99;
    @(negedge clk_i);
    chk("rw_late_d_res", d_res_valid_o, 0);
    chk("rw_late_i_res", i_res_valid_o, 0);
    @(posedge clk_i); #1;
    mem_res_valid_i = 0; mem_res_data_i = 0;
    @(negedge clk_i);
    chk("rw_late_err", err_o, 1);
    @(posedge clk_i); #1;

    // Both valid continuously after reset: D first, then alternate.
    do_reset();
    i_req_valid_i = 1; i_req_addr_i = 32'hA00; i_req_uncached_i = 0;
    d_req_valid_i = 1; d_req_addr_i = 32'hB00; d_req_rw_i = 0; d_req_wdata_i = 0;
    d_req_uncached_i = 0;
    do_txn(1'b1, 32'hB00, 1'b0, '0, 1'b0, 128'h11, 0, 1'b0);
    do_txn(1'b0, 32'hA00, 1'b0, '0, 1'b0, 128'h22, 0, 1'b0);
    do_txn(1'b1, 32'hB00, 1'b0, '0, 1'b0, 128'h33, 0, 1'b0);
    do_txn(1'b0, 32'hA00, 1'b0, '0, 1'b0, 128'h44, 0, 1'b0);
    i_req_valid_i = 0; d_req_valid_i = 0;

    repeat (3) @(posedge clk_i);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
